// File: rtl/ls_mem_ctrl.sv
// ls_mem_ctrl: load/store stage sequencer.
// Runs one data-memory transaction per L/S instruction over a req/gnt/rvalid
// handshake. It holds the upstream pipeline while the access is in flight,
// places store data and the byte mask in the right lanes, and aligns and
// extends load data for writeback.
//
// Optional build macro: LS_TIMEOUT_EN
//   Adds an 8-bit watchdog. When a request waits TIMEOUT_CYCLES cycles for
//   gnt/rvalid, the access is abandoned and reported through ls_err_o.
//   Without the macro the sequencer waits indefinitely.
//
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   ls_valid_i       L/S register holds a valid instruction
//   mem_wren_i       store enable
//   mem_lden_i       load enable
//   mem_op_i         funct3: B/H/W/D, BU/HU/WU, 111 reserved
//   addr_i           byte address
//   wdata_i          store data
//   ls_stall_o       hold upstream pipeline registers (combinational)
//   ldata_o          aligned, extended load result (held until next load)
//   ldata_valid_o    one-cycle strobe, ldata_o valid
//   ls_err_o         one-cycle strobe: misaligned/reserved/illegal access
//   dmem_req_o       memory request
//   dmem_we_o        1 = write
//   dmem_addr_o      8-byte-aligned address
//   dmem_wdata_o     lane-shifted store data
//   dmem_wmask_o     byte write mask
//   dmem_gnt_i       request accepted
//   dmem_rvalid_i    read data valid
//   dmem_rdata_i     read data
module ls_mem_ctrl #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ls_valid_i,
  input  logic            mem_wren_i,
  input  logic            mem_lden_i,
  input  logic [2:0]      mem_op_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ls_stall_o,
  output logic [XLEN-1:0] ldata_o,
  output logic            ldata_valid_o,
  output logic            ls_err_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [7:0]      dmem_wmask_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i
);

  localparam int unsigned MASK_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_D  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [2:0] OP_WU = 3'b110;
  localparam logic [2:0] OP_RS = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Elaboration-time parameter sanity checks.
  if (XLEN != 64) begin : g_bad_xlen
    $error("ls_mem_ctrl: only XLEN=64 is supported");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("ls_mem_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  // State and capture registers.
  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic              we_q, we_d;
  logic [2:0]        op_q, op_d;
  logic [2:0]        shift_q, shift_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   ldata_q, ldata_d;
  logic              ldata_valid_q, ldata_valid_d;
  logic              ls_err_q, ls_err_d;

  logic              start_c;
  logic              misalign_c;
  logic              bad_c;
  logic [MASK_W-1:0] mask_c;
  logic [XLEN-1:0]   rshift_c;
  logic [XLEN-1:0]   lfmt_c;
  logic              tmo_c;

  // Request decode, evaluated against the live L/S register contents.
  assign start_c = ls_valid_i & (mem_wren_i | mem_lden_i);

  always_comb begin
    misalign_c = 1'b0;
    unique case (mem_op_i[1:0])
      2'b00:   misalign_c = 1'b0;
      2'b01:   misalign_c = addr_i[0];
      2'b10:   misalign_c = (addr_i[1:0] != 2'b00);
      default: misalign_c = (addr_i[2:0] != 3'b000);
    endcase
  end

  // Stores have no unsigned/reserved forms, so any op with bit 2 set is illegal.
  assign bad_c = (mem_wren_i & mem_lden_i)
               | (mem_op_i == OP_RS)
               | misalign_c
               | (mem_wren_i & mem_op_i[2]);

  always_comb begin
    mask_c = '0;
    unique case (mem_op_i[1:0])
      2'b00:   mask_c = MASK_W'(8'h01) << addr_i[2:0];
      2'b01:   mask_c = MASK_W'(8'h03) << addr_i[2:0];
      2'b10:   mask_c = MASK_W'(8'h0F) << addr_i[2:0];
      default: mask_c = MASK_W'(8'hFF);
    endcase
  end

  // Load alignment: bring the addressed byte to lane 0, then extend.
  assign rshift_c = dmem_rdata_i >> {shift_q, 3'b000};

  always_comb begin
    lfmt_c = rshift_c;
    unique case (op_q)
      OP_B:    lfmt_c = {{(XLEN-8){rshift_c[7]}},   rshift_c[7:0]};
      OP_H:    lfmt_c = {{(XLEN-16){rshift_c[15]}}, rshift_c[15:0]};
      OP_W:    lfmt_c = {{(XLEN-32){rshift_c[31]}}, rshift_c[31:0]};
      OP_BU:   lfmt_c = {{(XLEN-8){1'b0}},  rshift_c[7:0]};
      OP_HU:   lfmt_c = {{(XLEN-16){1'b0}}, rshift_c[15:0]};
      OP_WU:   lfmt_c = {{(XLEN-32){1'b0}}, rshift_c[31:0]};
      OP_D:    lfmt_c = rshift_c;
      default: lfmt_c = rshift_c;
    endcase
  end

`ifdef LS_TIMEOUT_EN
  // Watchdog: zero while idle (so it starts at 0 on entry to REQ),
  // counts every cycle spent in REQ/RESP.
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_IDLE) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_REQ) || (state_q == S_RESP)) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Expires in the TIMEOUT_CYCLES-th waiting cycle.
  assign tmo_c = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    we_d          = we_q;
    op_d          = op_q;
    shift_d       = shift_q;
    ldata_d       = ldata_q;
    req_d         = 1'b0;
    ldata_valid_d = 1'b0;
    ls_err_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_c) begin
          if (bad_c) begin
            state_d  = S_DONE;
            ls_err_d = 1'b1;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = {addr_i[XLEN-1:3], 3'b000};
            wdata_d = wdata_i << {addr_i[2:0], 3'b000};
            wmask_d = mask_c;
            we_d    = mem_wren_i;
            op_d    = mem_op_i;
            shift_d = addr_i[2:0];
          end
        end
      end

      S_REQ: begin
        if (dmem_gnt_i) begin
          if (we_q) begin
            state_d = S_DONE;
          end else if (dmem_rvalid_i) begin
            state_d       = S_DONE;
            ldata_d       = lfmt_c;
            ldata_valid_d = 1'b1;
          end else begin
            state_d = S_RESP;
          end
        end else if (tmo_c) begin
          state_d  = S_DONE;
          ls_err_d = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end

      S_RESP: begin
        if (dmem_rvalid_i) begin
          state_d       = S_DONE;
          ldata_d       = lfmt_c;
          ldata_valid_d = 1'b1;
        end else if (tmo_c) begin
          state_d  = S_DONE;
          ls_err_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      we_q          <= 1'b0;
      op_q          <= 3'b000;
      shift_q       <= 3'b000;
      req_q         <= 1'b0;
      ldata_q       <= '0;
      ldata_valid_q <= 1'b0;
      ls_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wmask_q       <= wmask_d;
      we_q          <= we_d;
      op_q          <= op_d;
      shift_q       <= shift_d;
      req_q         <= req_d;
      ldata_q       <= ldata_d;
      ldata_valid_q <= ldata_valid_d;
      ls_err_q      <= ls_err_d;
    end
  end

  // Stall is combinational so a new access holds the pipeline in its first
  // cycle; it is gated by rstn so every output reads 0 while in reset.
  assign ls_stall_o = rstn & (((state_q == S_IDLE) & start_c)
                              | (state_q == S_REQ)
                              | (state_q == S_RESP));

  assign ldata_o       = ldata_q;
  assign ldata_valid_o = ldata_valid_q;
  assign ls_err_o      = ls_err_q;
  assign dmem_req_o    = req_q;
  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_wdata_o  = wdata_q;
  assign dmem_wmask_o  = wmask_q;

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// tb_ls_mem_ctrl: self-checking bench for ls_mem_ctrl.
// Directed cases followed by randomized loads/stores/illegal accesses; the
// expected bus image and load results come from a byte-level model.
module tb_ls_mem_ctrl;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rstn;
  logic        ls_valid;
  logic        mem_wren;
  logic        mem_lden;
  logic [2:0]  mem_op;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        ls_stall;
  logic [63:0] ldata;
  logic        ldata_valid;
  logic        ls_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;

  int          checks;
  int          errors;
  logic [63:0] exp_ldata;

  ls_mem_ctrl #(.XLEN(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ls_valid_i   (ls_valid),
    .mem_wren_i   (mem_wren),
    .mem_lden_i   (mem_lden),
    .mem_op_i     (mem_op),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .ls_stall_o   (ls_stall),
    .ldata_o      (ldata),
    .ldata_valid_o(ldata_valid),
    .ls_err_o     (ls_err),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_wmask_o (dmem_wmask),
    .dmem_gnt_i   (dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    ls_valid    = 1'b0;
    mem_wren    = 1'b0;
    mem_lden    = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  // One instruction from IDLE through DONE plus one trailing idle cycle.
  // gdly: cycles gnt is withheld in REQ; rdly: cycles after gnt until rvalid.
  task automatic run_txn(input bit we, input bit le, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input int gdly, input int rdly);
    int          n;
    int          s;
    int          mi;
    bit          bad;
    logic [7:0]  m;
    logic [63:0] bm;
    logic [63:0] ew;
    logic [63:0] r;
    logic [63:0] keep;
    logic [63:0] el;
    n   = 1 << op[1:0];
    s   = int'(a[2:0]);
    bad = (we && le) || (op == 3'd7) || ((a % 64'(n)) != 0) || (we && op[2]);
    mi  = ((1 << n) - 1) << s;
    m   = 8'(mi);
    for (int k = 0; k < 8; k++) bm[8*k +: 8] = {8{m[k]}};
    ew  = wd << (8 * s);
    r   = rd >> (8 * s);
    if (n == 8) begin
      el = r;
    end else begin
      keep = (64'd1 << (8 * n)) - 64'd1;
      el   = r & keep;
      if (!op[2] && r[8*n-1]) el = el | ~keep;
    end

    // IDLE cycle with start
    @(negedge clk);
    ls_valid = 1'b1; mem_wren = we; mem_lden = le; mem_op = op;
    addr = a; wdata = wd; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    check_eq("idle_stall", 64'(ls_stall), 64'd1);
    check_eq("idle_req", 64'(dmem_req), 64'd0);

    if (bad) begin
      @(negedge clk);
      #1;
      check_eq("err_stall", 64'(ls_stall), 64'd0);
      check_eq("err_strobe", 64'(ls_err), 64'd1);
      check_eq("err_req", 64'(dmem_req), 64'd0);
      check_eq("err_ldv", 64'(ldata_valid), 64'd0);
      check_eq("err_ldata_hold", ldata, exp_ldata);
    end else begin
      for (int i = 0; i <= gdly; i++) begin
        @(negedge clk);
        dmem_gnt    = (i == gdly);
        dmem_rvalid = le && (rdly == 0) && (i == gdly);
        dmem_rdata  = dmem_rvalid ? rd : {$urandom, $urandom};
        #1;
        check_eq("req_req", 64'(dmem_req), 64'd1);
        check_eq("req_stall", 64'(ls_stall), 64'd1);
        check_eq("req_addr", dmem_addr, a & ~64'd7);
        check_eq("req_we", 64'(dmem_we), 64'(we));
        check_eq("req_mask", 64'(dmem_wmask), 64'(m));
        if (we) check_eq("req_wdata", dmem_wdata & bm, ew & bm);
      end
      if (le && rdly > 0) begin
        for (int j = 1; j <= rdly; j++) begin
          @(negedge clk);
          dmem_gnt    = 1'b0;
          dmem_rvalid = (j == rdly);
          dmem_rdata  = dmem_rvalid ? rd : {$urandom, $urandom};
          #1;
          check_eq("resp_req", 64'(dmem_req), 64'd0);
          check_eq("resp_stall", 64'(ls_stall), 64'd1);
        end
      end
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      #1;
      check_eq("done_stall", 64'(ls_stall), 64'd0);
      check_eq("done_req", 64'(dmem_req), 64'd0);
      check_eq("done_err", 64'(ls_err), 64'd0);
      check_eq("done_ldv", 64'(ldata_valid), 64'(le));
      if (le) exp_ldata = el;
      check_eq("done_ldata", ldata, exp_ldata);
    end

    // Pipeline advanced: next cycle idle
    @(negedge clk);
    drive_idle();
    ls_valid = 1'($urandom_range(0, 1));
    #1;
    check_eq("post_stall", 64'(ls_stall), 64'd0);
    check_eq("post_ldv", 64'(ldata_valid), 64'd0);
    check_eq("post_err", 64'(ls_err), 64'd0);
    check_eq("post_ldata", ldata, exp_ldata);
  endtask

  initial begin
    bit          we;
    bit          le;
    logic [2:0]  op;
    logic [63:0] a;
    int          kind;
    int          n;
    int          gmax;
    int          rmax;

    checks    = 0;
    errors    = 0;
    exp_ldata = 64'd0;
    rstn      = 1'b0;
    mem_op    = 3'd0;
    addr      = 64'd0;
    wdata     = 64'd0;
    dmem_rdata = 64'd0;
    drive_idle();

    // Reset state
    #3;
    check_eq("rst_stall", 64'(ls_stall), 64'd0);
    check_eq("rst_req", 64'(dmem_req), 64'd0);
    check_eq("rst_ldata", ldata, 64'd0);
    check_eq("rst_mask", 64'(dmem_wmask), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Directed cases
    run_txn(1'b1, 1'b0, 3'b000, 64'h80000003, 64'hAB, 64'd0, 0, 0);
    run_txn(1'b0, 1'b1, 3'b001, 64'h80000006, 64'd0, 64'h8001000000000000, 0, 1);
    check_eq("lh_result", ldata, 64'hFFFFFFFFFFFF8001);
    run_txn(1'b0, 1'b1, 3'b101, 64'h80000006, 64'd0, 64'h8001000000000000, 0, 1);
    check_eq("lhu_result", ldata, 64'h0000000000008001);
    run_txn(1'b1, 1'b0, 3'b011, 64'h80001008, 64'h0123456789ABCDEF, 64'd0, 3, 0);
    run_txn(1'b0, 1'b1, 3'b011, 64'h80001010, 64'd0, 64'hFEDCBA9876543210, 0, 0);
    check_eq("ld_result", ldata, 64'hFEDCBA9876543210);
    run_txn(1'b0, 1'b1, 3'b010, 64'h80000002, 64'd0, 64'd0, 0, 0);
    run_txn(1'b1, 1'b1, 3'b000, 64'h80000000, 64'd0, 64'd0, 0, 0);
    run_txn(1'b0, 1'b1, 3'b111, 64'h80000000, 64'd0, 64'd0, 0, 0);
    run_txn(1'b1, 1'b0, 3'b100, 64'h80000000, 64'd0, 64'd0, 0, 0);

    // Randomized traffic
`ifdef LS_TIMEOUT_EN
    gmax = 1; rmax = 2;
`else
    gmax = 3; rmax = 3;
`endif
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      a    = {$urandom, $urandom};
      if (kind < 4) begin
        we = 1'b0; le = 1'b1; op = 3'($urandom_range(0, 6));
      end else if (kind < 8) begin
        we = 1'b1; le = 1'b0; op = 3'($urandom_range(0, 3));
      end else if (kind == 8) begin
        we = 1'($urandom_range(0, 1)); le = !we; op = 3'($urandom_range(0, 7));
      end else begin
        we = 1'b1; le = 1'b1; op = 3'($urandom_range(0, 7));
      end
      if (kind < 8) begin
        n = 1 << op[1:0];
        a = a & ~(64'(n) - 64'd1);
      end
      run_txn(we, le, op, a, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, gmax), $urandom_range(0, rmax));
    end

`ifdef LS_TIMEOUT_EN
    // Grant never arrives: request abandoned after TO cycles
    @(negedge clk);
    ls_valid = 1'b1; mem_wren = 1'b0; mem_lden = 1'b1; mem_op = 3'b011;
    addr = 64'h80000100; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    check_eq("tmo_idle_stall", 64'(ls_stall), 64'd1);
    for (int i = 0; i < int'(TO); i++) begin
      @(negedge clk);
      #1;
      check_eq("tmo_req", 64'(dmem_req), 64'd1);
    end
    @(negedge clk);
    #1;
    check_eq("tmo_done_req", 64'(dmem_req), 64'd0);
    check_eq("tmo_done_err", 64'(ls_err), 64'd1);
    check_eq("tmo_done_ldv", 64'(ldata_valid), 64'd0);
    check_eq("tmo_done_stall", 64'(ls_stall), 64'd0);
    @(negedge clk);
    drive_idle();
    #1;
    check_eq("tmo_post_err", 64'(ls_err), 64'd0);
    check_eq("tmo_post_req", 64'(dmem_req), 64'd0);
`endif

    // Reset while waiting in RESP; late rvalid must be ignored
    @(negedge clk);
    ls_valid = 1'b1; mem_wren = 1'b0; mem_lden = 1'b1; mem_op = 3'b000;
    addr = 64'h80000200; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    check_eq("resp_pre_rst_stall", 64'(ls_stall), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_stall", 64'(ls_stall), 64'd0);
    check_eq("arst_req", 64'(dmem_req), 64'd0);
    check_eq("arst_we", 64'(dmem_we), 64'd0);
    check_eq("arst_addr", dmem_addr, 64'd0);
    check_eq("arst_wdata", dmem_wdata, 64'd0);
    check_eq("arst_mask", 64'(dmem_wmask), 64'd0);
    check_eq("arst_ldata", ldata, 64'd0);
    check_eq("arst_ldv", 64'(ldata_valid), 64'd0);
    check_eq("arst_err", 64'(ls_err), 64'd0);
    exp_ldata = 64'd0;
    @(negedge clk);
    drive_idle();
    rstn        = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h00000000000000FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_rvalid = (i == 0);
      #1;
      check_eq("late_rvalid_ldv", 64'(ldata_valid), 64'd0);
      check_eq("late_rvalid_req", 64'(dmem_req), 64'd0);
      check_eq("late_rvalid_ldata", ldata, exp_ldata);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
